gen_controller: RTL and testbench
=================================

GEN_CONTROLLER -- requirements
Module: gen_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: port clk, port rst.
REQ-002 The block SHALL provide parameter BOARD_N, default 16, meaning board side length; row index width is clog2(BOARD_N).
REQ-003 The block SHALL provide parameter PERIOD_W, default 24, meaning generation-period counter width.
REQ-004 The block SHALL provide parameter GEN_W, default 16, meaning generation counter width.
REQ-005 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- cmd_run  in  1  start free-running generations
- cmd_step  in  1  run exactly one generation
- cmd_stop  in  1  halt after the current generation
- period  in  PERIOD_W  clk cycles between generation starts
- load_valid  in  1  row-load request
- load_row  in  4  row index
- load_data  in  BOARD_N  row cells, bit j = column j
- load_ready  out  1  load accepted this cycle
- mem_we  out  1  board-bank row write
- mem_bank  out  1  bank written
- mem_row  out  4  row written
- mem_data  out  BOARD_N  row data written
- eng_start  out  1  one-cycle pulse that starts the update datapath
- eng_src_bank  out  1  bank the datapath reads; it writes the other bank
- eng_done  in  1  one-cycle pulse, generation complete
- eng_births  in  9  births in the completed generation (0..256)
- eng_deaths  in  9  deaths in the completed generation
- disp_bank  out  1  bank holding the current displayed board
- gen_count  out  GEN_W  completed generations
- last_births  out  9  latched births
- last_deaths  out  9  latched deaths
- stable  out  1  last generation had no births and no deaths
- busy  out  1  state is not IDLE

Function
REQ-006 The FSM SHALL have states IDLE, WAIT, START, BUSY and SWAP.
REQ-007 In IDLE: cmd_stop SHALL be ignored; cmd_step SHALL go to START with run_mode=0; cmd_run SHALL go to WAIT with run_mode=1 and the timer loaded.
REQ-008 Command priority SHALL be stop > step > run when asserted in the same cycle.
REQ-009 In WAIT, the timer SHALL decrement each cycle; at 1 the FSM SHALL go to START; period==0 SHALL be treated as 1.
REQ-010 In WAIT, cmd_stop SHALL return the FSM to IDLE on the next cycle without starting a generation.
REQ-011 START SHALL last one cycle with eng_start=1 and eng_src_bank=disp_bank, then go to BUSY.
REQ-012 BUSY SHALL hold until eng_done=1, with no timeout.
- eng_done outside BUSY SHALL be ignored.
REQ-013 On entering SWAP (the cycle after eng_done), the block SHALL:
- toggle disp_bank;
- increment gen_count, wrapping modulo 2^GEN_W;
- latch eng_births and eng_deaths into last_births and last_deaths;
- set stable = (births==0 && deaths==0).
REQ-014 From SWAP the FSM SHALL go to IDLE if run_mode=0, stop_pending=1 or stable=1; otherwise it SHALL go to WAIT with the timer reloaded.
REQ-015 cmd_stop during START, BUSY or SWAP SHALL set stop_pending; stop_pending SHALL be cleared on entry to IDLE.
REQ-016 load_ready SHALL equal (state==IDLE).
- A load_valid with load_ready SHALL produce mem_we=1, mem_bank=disp_bank, mem_row=load_row and mem_data=load_data in the same cycle.
- Loads outside IDLE SHALL be dropped.
REQ-017 Any accepted load SHALL clear stable.
- A load coincident with a command SHALL be written first; the command takes effect the same cycle.
REQ-018 Commands arriving during WAIT, START, BUSY or SWAP, other than cmd_stop, SHALL be ignored.

Reset
REQ-019 While rst=1, the block SHALL hold state=IDLE, disp_bank=0, gen_count=0, last_births=0, last_deaths=0, stable=0, eng_start=0, mem_we=0, run_mode=0, stop_pending=0 and timer=0.
REQ-020 Reset asserted mid-generation SHALL abandon the generation; a later eng_done SHALL be ignored.

Structure
REQ-021 The FSM state encoding, the BOARD_N default and the count width (9) SHALL reside in a shared life_pkg package.
REQ-022 The period timer SHALL be a sub-module named gen_timer, with inputs load, value and enable and output expire.

Verification
REQ-023 The bench SHALL cover: reset, then cmd_step, then eng_done after 20 cycles with births=3 and deaths=1 -> eng_start exactly once, gen_count=1, disp_bank=1, last_births=3, last_deaths=1, stable=0, IDLE.
REQ-024 The bench SHALL cover: cmd_run with period=5 and eng_done 2 cycles after each start -> eng_start pulses 5+1+2+1=9 cycles apart.
REQ-025 The bench SHALL cover: cmd_stop during BUSY -> the generation completes, gen_count increments by 1, the FSM returns to IDLE and no further eng_start occurs.
REQ-026 The bench SHALL cover: running with eng_done reporting births=0 and deaths=0 -> stable=1 and auto-halt to IDLE.
REQ-027 The bench SHALL cover: load row 7 = 16'hA5A5 in IDLE -> mem_we=1, mem_row=7 and mem_data=16'hA5A5 the same cycle; the same load during BUSY -> mem_we=0.
REQ-028 The bench SHALL cover: rst asserted during BUSY, then eng_done -> all outputs at reset values, gen_count=0.

Source files
------------

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared types and constants for the life-board generation
//               controller (FSM state encoding, board size, count width).
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

   // Default side length of the square board.
   localparam int unsigned LIFE_BOARD_N = 16;

   // Width of the per-generation birth/death counts (0..256 fits in 9 bits).
   localparam int unsigned CNT_W = 9;

   // Generation controller states.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_START = 3'd2,
      S_BUSY  = 3'd3,
      S_SWAP  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gen_timer.sv
`default_nettype none
// ============================================================================
// Module      : gen_timer
// Description : Down-counting period timer. A load captures the period
//               (zero is promoted to one); expire flags the final count.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_timer #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             enable,
   output logic             expire
);

   localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_zero = '0;

   logic [WIDTH-1:0] r_count;

   // Load the period (minimum one cycle) or count down while enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= c_zero;
      end else if (load) begin
         r_count <= (value == c_zero) ? c_one : value;
      end else if (enable && (r_count != c_zero)) begin
         r_count <= r_count - c_one;
      end
   end

   assign expire = enable && (r_count == c_one);

endmodule
`default_nettype wire

// File: rtl/gen_controller.sv
`default_nettype none
// ============================================================================
// Module      : gen_controller
// Description : Sequences life-board generations: accepts row loads while
//               idle, launches the update datapath on step/run commands,
//               paces free-running generations and tracks statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_controller
   import life_pkg::*;
#(
   parameter int BOARD_N  = LIFE_BOARD_N,
   parameter int PERIOD_W = 24,
   parameter int GEN_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_run,
   input  logic                       cmd_step,
   input  logic                       cmd_stop,
   input  logic [PERIOD_W-1:0]        period,
   input  logic                       load_valid,
   input  logic [$clog2(BOARD_N)-1:0] load_row,
   input  logic [BOARD_N-1:0]         load_data,
   output logic                       load_ready,
   output logic                       mem_we,
   output logic                       mem_bank,
   output logic [$clog2(BOARD_N)-1:0] mem_row,
   output logic [BOARD_N-1:0]         mem_data,
   output logic                       eng_start,
   output logic                       eng_src_bank,
   input  logic                       eng_done,
   input  logic [CNT_W-1:0]           eng_births,
   input  logic [CNT_W-1:0]           eng_deaths,
   output logic                       disp_bank,
   output logic [GEN_W-1:0]           gen_count,
   output logic [CNT_W-1:0]           last_births,
   output logic [CNT_W-1:0]           last_deaths,
   output logic                       stable,
   output logic                       busy
);

   state_t r_state;
   logic   r_run_mode;
   logic   r_stop_pending;

   logic   w_load_accept;
   logic   w_idle_run;
   logic   w_continue;
   logic   w_timer_load;
   logic   w_timer_en;
   logic   w_expire;

   // Row loads pass straight through to the displayed bank while idle.
   assign load_ready    = (r_state == S_IDLE);
   assign w_load_accept = load_valid && load_ready && !rst;
   assign mem_we        = w_load_accept;
   assign mem_bank      = disp_bank;
   assign mem_row       = load_row;
   assign mem_data      = load_data;

   assign eng_src_bank  = disp_bank;
   assign busy          = (r_state != S_IDLE);

   // Stop outranks step, which outranks run, even in IDLE.
   assign w_idle_run    = (r_state == S_IDLE) && !cmd_stop && !cmd_step && cmd_run;
   // Free-running continues unless stopped or the board has settled.
   assign w_continue    = r_run_mode && !r_stop_pending && !cmd_stop && !stable;
   assign w_timer_load  = w_idle_run || ((r_state == S_SWAP) && w_continue);
   assign w_timer_en    = (r_state == S_WAIT);

   gen_timer #(
      .WIDTH (PERIOD_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (w_timer_load),
      .value  (period),
      .enable (w_timer_en),
      .expire (w_expire)
   );

   // Generation sequencing FSM with registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_run_mode     <= 1'b0;
         r_stop_pending <= 1'b0;
         eng_start      <= 1'b0;
         disp_bank      <= 1'b0;
         gen_count      <= '0;
         last_births    <= '0;
         last_deaths    <= '0;
         stable         <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         if (w_load_accept) begin
            stable <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               r_stop_pending <= 1'b0;
               if (cmd_stop) begin
                  r_state <= S_IDLE;
               end else if (cmd_step) begin
                  r_state    <= S_START;
                  r_run_mode <= 1'b0;
                  eng_start  <= 1'b1;
               end else if (cmd_run) begin
                  r_state    <= S_WAIT;
                  r_run_mode <= 1'b1;
               end
            end
            S_WAIT: begin
               if (cmd_stop) begin
                  r_state        <= S_IDLE;
                  r_stop_pending <= 1'b0;
               end else if (w_expire) begin
                  r_state   <= S_START;
                  eng_start <= 1'b1;
               end
            end
            S_START: begin
               if (cmd_stop) begin
                  r_stop_pending <= 1'b1;
               end
               r_state <= S_BUSY;
            end
            S_BUSY: begin
               if (cmd_stop) begin
                  r_stop_pending <= 1'b1;
               end
               if (eng_done) begin
                  r_state     <= S_SWAP;
                  disp_bank   <= ~disp_bank;
                  gen_count   <= gen_count + GEN_W'(1);
                  last_births <= eng_births;
                  last_deaths <= eng_deaths;
                  stable      <= (eng_births == '0) && (eng_deaths == '0);
               end
            end
            S_SWAP: begin
               if (w_continue) begin
                  r_state <= S_WAIT;
               end else begin
                  r_state        <= S_IDLE;
                  r_stop_pending <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gen_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_controller
// Description : Self-checking bench for gen_controller; expected generation
//               results are queued when eng_done is driven and compared when
//               the controller publishes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_controller;
   import life_pkg::*;

   localparam int BOARD_N  = 16;
   localparam int PERIOD_W = 24;
   localparam int GEN_W    = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                cmd_run, cmd_step, cmd_stop;
   logic [PERIOD_W-1:0] period;
   logic                load_valid;
   logic [3:0]          load_row;
   logic [BOARD_N-1:0]  load_data;
   logic                load_ready, mem_we, mem_bank;
   logic [3:0]          mem_row;
   logic [BOARD_N-1:0]  mem_data;
   logic                eng_start, eng_src_bank, eng_done;
   logic [CNT_W-1:0]    eng_births, eng_deaths;
   logic                disp_bank;
   logic [GEN_W-1:0]    gen_count;
   logic [CNT_W-1:0]    last_births, last_deaths;
   logic                stable, busy;

   gen_controller #(
      .BOARD_N  (BOARD_N),
      .PERIOD_W (PERIOD_W),
      .GEN_W    (GEN_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_run      (cmd_run),
      .cmd_step     (cmd_step),
      .cmd_stop     (cmd_stop),
      .period       (period),
      .load_valid   (load_valid),
      .load_row     (load_row),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .mem_we       (mem_we),
      .mem_bank     (mem_bank),
      .mem_row      (mem_row),
      .mem_data     (mem_data),
      .eng_start    (eng_start),
      .eng_src_bank (eng_src_bank),
      .eng_done     (eng_done),
      .eng_births   (eng_births),
      .eng_deaths   (eng_deaths),
      .disp_bank    (disp_bank),
      .gen_count    (gen_count),
      .last_births  (last_births),
      .last_deaths  (last_deaths),
      .stable       (stable),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [GEN_W-1:0] gen;
      logic             bank;
      logic [CNT_W-1:0] births;
      logic [CNT_W-1:0] deaths;
      logic             stab;
   } exp_t;

   exp_t             sb_q[$];
   int               n_checks = 0;
   int               n_errors = 0;
   int               cyc      = 0;
   int               n_starts = 0;
   logic [GEN_W-1:0] m_gen    = '0;
   logic             m_disp   = 1'b0;

   // Cycle counter and eng_start pulse counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (eng_start) n_starts <= n_starts + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until eng_start is seen; returns the cycle it was seen.
   task automatic wait_start(output int at);
      bit seen = 0;
      at = -1;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (eng_start) begin
            seen = 1;
            at   = cyc;
         end
      end
      if (!seen) chk("start_timeout", 32'd0, 32'd1);
   endtask

   // Pulse eng_done (DUT in BUSY), queue the expected result, then compare.
   task automatic finish_gen(input int b, input int d);
      exp_t e, g;
      eng_done   = 1'b1;
      eng_births = CNT_W'(b);
      eng_deaths = CNT_W'(d);
      m_gen      = m_gen + 1'b1;
      m_disp     = ~m_disp;
      e.gen = m_gen; e.bank = m_disp; e.births = CNT_W'(b);
      e.deaths = CNT_W'(d); e.stab = (b == 0) && (d == 0);
      sb_q.push_back(e);
      tick();
      eng_done = 1'b0;
      g = sb_q.pop_front();
      chk("gen_count",   32'(gen_count),   32'(g.gen));
      chk("disp_bank",   32'(disp_bank),   32'(g.bank));
      chk("last_births", 32'(last_births), 32'(g.births));
      chk("last_deaths", 32'(last_deaths), 32'(g.deaths));
      chk("stable",      32'(stable),      32'(g.stab));
   endtask

   initial begin
      int c1, c2, snap;
      rst = 1'b1; cmd_run = 0; cmd_step = 0; cmd_stop = 0; period = '0;
      load_valid = 1'b1; load_row = 4'd3; load_data = 16'h1234;
      eng_done = 0; eng_births = '0; eng_deaths = '0;
      repeat (3) tick();
      chk("rst_gen", 32'(gen_count), 0);
      chk("rst_disp", 32'(disp_bank), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_stable", 32'(stable), 0);
      chk("rst_start", 32'(eng_start), 0);
      load_valid = 1'b0;
      rst = 1'b0;
      tick();

      // Single step: one start, results latched, back to IDLE.
      snap = n_starts;
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      chk("step_start", 32'(eng_start), 1);
      chk("step_src_bank", 32'(eng_src_bank), 0);
      repeat (19) tick();
      finish_gen(3, 1);
      tick();
      chk("step_idle", 32'(busy), 0);
      chk("step_nstarts", 32'(n_starts - snap), 1);

      // Free run, period 5: starts 9 cycles apart; stop in WAIT.
      period = 24'd5;
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      wait_start(c1);
      chk("run_src_bank", 32'(eng_src_bank), 32'(m_disp));
      tick(); tick();
      finish_gen(2, 0);
      wait_start(c2);
      chk("run_spacing1", 32'(c2 - c1), 9);
      c1 = c2;
      tick(); tick();
      finish_gen(2, 0);
      wait_start(c2);
      chk("run_spacing2", 32'(c2 - c1), 9);
      tick(); tick();
      finish_gen(4, 4);
      tick();
      chk("run_in_wait", 32'(busy), 1);
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      chk("wait_stop_idle", 32'(busy), 0);
      snap = n_starts;
      repeat (12) tick();
      chk("wait_stop_nostart", 32'(n_starts - snap), 0);

      // Period 0 acts as 1; then stop during BUSY completes the generation.
      period = '0;
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      wait_start(c1);
      tick(); tick();
      finish_gen(1, 0);
      wait_start(c2);
      chk("p0_spacing", 32'(c2 - c1), 5);
      tick();
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      finish_gen(1, 2);
      tick();
      chk("busy_stop_idle", 32'(busy), 0);
      snap = n_starts;
      repeat (15) tick();
      chk("busy_stop_nostart", 32'(n_starts - snap), 0);

      // Settled board halts free running.
      period = 24'd2;
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      wait_start(c1);
      tick();
      finish_gen(0, 0);
      tick();
      chk("stable_halt", 32'(busy), 0);
      snap = n_starts;
      repeat (15) tick();
      chk("stable_nostart", 32'(n_starts - snap), 0);

      // Row load in IDLE writes the displayed bank and clears stable.
      load_valid = 1'b1; load_row = 4'd7; load_data = 16'hA5A5;
      #1;
      chk("load_ready", 32'(load_ready), 1);
      chk("load_we", 32'(mem_we), 1);
      chk("load_row", 32'(mem_row), 7);
      chk("load_data", 32'(mem_data), 32'h0000A5A5);
      chk("load_bank", 32'(mem_bank), 32'(m_disp));
      tick();
      load_valid = 1'b0;
      chk("load_clr_stable", 32'(stable), 0);

      // Same load during BUSY is dropped.
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      tick();
      load_valid = 1'b1;
      #1;
      chk("busy_load_we", 32'(mem_we), 0);
      chk("busy_load_ready", 32'(load_ready), 0);
      load_valid = 1'b0;
      finish_gen(5, 5);
      tick();

      // Reset mid-generation abandons it; a later eng_done is ignored.
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_gen", 32'(gen_count), 0);
      chk("midrst_busy", 32'(busy), 0);
      tick();
      rst = 1'b0;
      m_gen = '0; m_disp = 1'b0;
      eng_done = 1'b1; eng_births = 9'd7; eng_deaths = 9'd7;
      tick();
      eng_done = 1'b0;
      tick();
      chk("postrst_gen", 32'(gen_count), 0);
      chk("postrst_disp", 32'(disp_bank), 0);
      chk("postrst_births", 32'(last_births), 0);
      chk("postrst_deaths", 32'(last_deaths), 0);
      chk("postrst_stable", 32'(stable), 0);
      chk("postrst_busy", 32'(busy), 0);
      chk("postrst_start", 32'(eng_start), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
